ram_port_arbiter: RTL and testbench

Two-port arbiter that shares the single SDRAM controller port between the CPU/DMA requester (port A, read/write, stall-driven) and the video/layer fetch requester (port B, read-only, latency-critical). It sits in `clk_sys` between `zxnext_top` RAM_A/RAM_B and the `sdram` command interface. It serialises requests, applies priority with a starvation guard, and recovers from a hung memory cycle with a watchdog.

---
 rtl/ram_port_arbiter_if.sv | 39 +++
 rtl/ram_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SDRAM controller
// command port. The arbiter uses the slave view; the requesters and the memory
// controller together form the master view.
//
// Handshake: every transfer is pulse based. a_req/b_req are one-cycle request
// strobes, and address, direction and data are sampled in that same cycle.
// mem_req is a one-cycle command strobe, and mem_we/mem_addr/mem_din are valid
// with it. mem_ack is a one-cycle completion strobe, and mem_dout is valid with
// it. b_valid pulses for one cycle when b_dout updates. a_wait is a level that
// stalls port A while its request is outstanding.
interface ram_port_arbiter_if;
    logic        a_req;
    logic        a_rd_n;
    logic [20:0] a_addr;
    logic [7:0]  a_din;
    logic [7:0]  a_dout;
    logic        a_wait;
    logic        b_req;
    logic [20:0] b_addr;
    logic [7:0]  b_dout;
    logic        b_valid;
    logic        mem_req;
    logic        mem_we;
    logic [20:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_ack;
    logic        err;

    modport master (
        output a_req, a_rd_n, a_addr, a_din, b_req, b_addr, mem_dout, mem_ack,
        input  a_dout, a_wait, b_dout, b_valid, mem_req, mem_we, mem_addr, mem_din, err
    );

    modport slave (
        input  a_req, a_rd_n, a_addr, a_din, b_req, b_addr, mem_dout, mem_ack,
        output a_dout, a_wait, b_dout, b_valid, mem_req, mem_we, mem_addr, mem_din, err
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single SDRAM controller port between the CPU/DMA port (A,
// read/write, stall driven) and the video fetch port (B, read only). B is
// favoured for latency, but a streak counter forces A through after
// B_STREAK_MAX consecutive B grants. A watchdog aborts any memory cycle that is
// never acknowledged and completes it with 0xFF data.
module ram_port_arbiter #(
    parameter int B_STREAK_MAX = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk_sys,
    input  logic              RESET,
    ram_port_arbiter_if.slave bus,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT_A = 2'd2,
        S_WAIT_B = 2'd3
    } state_t;

    localparam logic [9:0] WD_LAST    = 10'(TIMEOUT - 1);
    localparam logic [2:0] STREAK_MAX = 3'(B_STREAK_MAX);

    state_t      state;
    logic        grant_b;
    logic [9:0]  wd_cnt;
    logic [2:0]  streak;

    logic        a_pend;
    logic        a_we_q;
    logic [20:0] a_addr_q;
    logic [7:0]  a_din_q;
    logic        b_pend;
    logic [20:0] b_addr_q;

    logic        wd_expire;
    logic        a_done;
    logic        b_done;

    // The watchdog fires on the WAIT cycle that brings the count up to TIMEOUT.
    assign wd_expire = (wd_cnt == WD_LAST);
    // A completion is either a real ack or a watchdog abort; an ack wins if both occur.
    assign a_done    = (state == S_WAIT_A) && (bus.mem_ack || wd_expire);
    assign b_done    = (state == S_WAIT_B) && (bus.mem_ack || wd_expire);
    assign bus.a_wait = bus.a_req | a_pend;
    assign state_dbg  = state;

    // Port A pending entry: a new request is accepted when the entry is empty or
    // is being retired this cycle; otherwise it is dropped.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            a_pend   <= 1'b0;
            a_we_q   <= 1'b0;
            a_addr_q <= '0;
            a_din_q  <= '0;
        end else if (bus.a_req && (!a_pend || a_done)) begin
            a_pend   <= 1'b1;
            a_we_q   <= bus.a_rd_n;
            a_addr_q <= bus.a_addr;
            a_din_q  <= bus.a_din;
        end else if (a_done) begin
            a_pend   <= 1'b0;
        end
    end

    // Port B pending entry, with the same accept/drop rule as port A.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            b_pend   <= 1'b0;
            b_addr_q <= '0;
        end else if (bus.b_req && (!b_pend || b_done)) begin
            b_pend   <= 1'b1;
            b_addr_q <= bus.b_addr;
        end else if (b_done) begin
            b_pend   <= 1'b0;
        end
    end

    // Count the B completions that A has had to sit through, saturating at the limit.
    always_ff @(posedge clk_sys) begin
        if (RESET || !a_pend || a_done) begin
            streak <= 3'd0;
        end else if (b_done && (streak < STREAK_MAX)) begin
            streak <= streak + 3'd1;
        end
    end

    // Arbitration FSM: choose a winner, strobe the command, then wait for the ack or the watchdog.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state        <= S_IDLE;
            grant_b      <= 1'b0;
            wd_cnt       <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.a_dout   <= '0;
            bus.b_dout   <= '0;
            bus.b_valid  <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.mem_req <= 1'b0;
            bus.b_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (b_pend && (!a_pend || (streak < STREAK_MAX))) begin
                        grant_b      <= 1'b1;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= b_addr_q;
                        bus.mem_din  <= 8'h00;
                        state        <= S_ISSUE;
                    end else if (a_pend) begin
                        grant_b      <= 1'b0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= a_we_q;
                        bus.mem_addr <= a_addr_q;
                        bus.mem_din  <= a_din_q;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // An ack in this cycle arrives with the command itself and is not accepted.
                    wd_cnt <= '0;
                    state  <= grant_b ? S_WAIT_B : S_WAIT_A;
                end
                S_WAIT_A: begin
                    if (a_done) begin
                        if (!a_we_q) begin
                            bus.a_dout <= bus.mem_ack ? bus.mem_dout : 8'hFF;
                        end
                        if (!bus.mem_ack) begin
                            bus.err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 10'd1;
                    end
                end
                S_WAIT_B: begin
                    if (b_done) begin
                        bus.b_dout  <= bus.mem_ack ? bus.mem_dout : 8'hFF;
                        bus.b_valid <= 1'b1;
                        if (!bus.mem_ack) begin
                            bus.err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 10'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a table of single transactions plus
// hand-written sequences for arbitration order, the starvation guard, the
// watchdog, reset in flight and duplicate requests. A small memory model acks
// commands after a programmable delay, and a scoreboard queue holds the
// command stream expected on the controller port.
module tb_ram_port_arbiter;
    logic       clk_sys;
    logic       RESET;
    logic [1:0] state_dbg;

    ram_port_arbiter_if bus();

    ram_port_arbiter #(.B_STREAK_MAX(4), .TIMEOUT(255)) dut (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    typedef struct {
        logic        is_b;
        logic        rd_n;
        logic [20:0] addr;
        logic [7:0]  din;
        int          n;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t        vecs [8];
    logic [29:0] exp_q [$];
    logic [7:0]  mem [logic [20:0]];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_req_cyc = -1;
    int          bv_cnt = 0;
    int          ack_delay = 1;
    int          refill_left = 0;
    bit          mem_on = 1'b1;
    bit          force_ack = 1'b0;
    bit          busy = 1'b0;
    bit          busy_we = 1'b0;
    logic [20:0] busy_addr = '0;
    logic [7:0]  busy_din = '0;
    int          cnt = 0;

    // Clock
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finished", $time);
        $fatal(1, "time limit");
    end

    function automatic logic [29:0] pack(input logic we, input logic [20:0] addr, input logic [7:0] din);
        return {we, addr, din};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the middle of the next cycle: clear request pulses, run the
    // memory model, score any command seen and note b_valid pulses.
    task automatic next_cycle();
        logic [29:0] e;
        @(negedge clk_sys);
        cyc++;
        bus.a_req   = 1'b0;
        bus.b_req   = 1'b0;
        bus.mem_ack = 1'b0;
        if (force_ack) begin
            bus.mem_ack  = 1'b1;
            bus.mem_dout = 8'hC3;
            force_ack    = 1'b0;
        end else if (busy) begin
            if (cnt <= 1) begin
                bus.mem_ack = 1'b1;
                if (busy_we) begin
                    mem[busy_addr] = busy_din;
                    bus.mem_dout   = 8'h00;
                end else begin
                    bus.mem_dout = mem.exists(busy_addr) ? mem[busy_addr] : (busy_addr[7:0] ^ 8'hA5);
                end
                busy = 1'b0;
                if (!busy_we && busy_addr[20] && (refill_left > 0)) begin
                    bus.b_req  = 1'b1;
                    bus.b_addr = busy_addr + 21'd1;
                    refill_left--;
                end
            end else begin
                cnt--;
            end
        end
        if (bus.mem_req) begin
            last_req_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_req_unexpected: got we=%0b addr=%06h, required no command", bus.mem_we, bus.mem_addr);
            end else begin
                e = exp_q.pop_front();
                if ((bus.mem_we !== e[29]) || (bus.mem_addr !== e[28:8]) || (e[29] && (bus.mem_din !== e[7:0]))) begin
                    errors++;
                    $display("FAIL mem_req_cmd: got we=%0b addr=%06h din=%02h, required we=%0b addr=%06h din=%02h",
                             bus.mem_we, bus.mem_addr, bus.mem_din, e[29], e[28:8], e[7:0]);
                end
            end
            if (mem_on) begin
                busy      = 1'b1;
                busy_we   = bus.mem_we;
                busy_addr = bus.mem_addr;
                busy_din  = bus.mem_din;
                cnt       = ack_delay;
            end
        end
        if (bus.b_valid) begin
            bv_cnt++;
        end
        #1;
    endtask

    task automatic wait_a_free(input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            next_cycle();
            if (!bus.a_wait) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_b_valid(input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            next_cycle();
            if (bus.b_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    // A and B requested in the same cycle: B is served first, then A.
    task automatic same_cycle_ab();
        int t0;
        int at;
        ack_delay = 1;
        exp_q.push_back(pack(1'b0, 21'h000233, 8'h00));
        exp_q.push_back(pack(1'b0, 21'h000100, 8'h00));
        next_cycle();
        t0 = cyc;
        bus.a_req  = 1'b1;
        bus.a_rd_n = 1'b0;
        bus.a_addr = 21'h000100;
        bus.b_req  = 1'b1;
        bus.b_addr = 21'h000233;
        wait_b_valid(20, at);
        check("ab_b_valid_cycle", 32'(at - t0), 32'd4);
        check("ab_b_dout", 32'(bus.b_dout), 32'h96);
        wait_a_free(20, at);
        check("ab_a_free_cycle", 32'(at - t0), 32'd7);
        check("ab_a_dout", 32'(bus.a_dout), 32'hA5);
        next_cycle();
    endtask

    initial begin
        int t0;
        int at;
        int bv0;

        vecs[0] = '{1'b0, 1'b1, 21'h012345, 8'h5A, 3, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 21'h012345, 8'h00, 3, 8'h5A};
        vecs[2] = '{1'b1, 1'b0, 21'h012345, 8'h00, 1, 8'h5A};
        vecs[3] = '{1'b1, 1'b0, 21'h000010, 8'h00, 2, 8'hB5};
        vecs[4] = '{1'b0, 1'b0, 21'h1FFFF0, 8'h00, 1, 8'h55};
        vecs[5] = '{1'b0, 1'b1, 21'h1FFFF0, 8'h00, 4, 8'h55};
        vecs[6] = '{1'b0, 1'b0, 21'h1FFFF0, 8'h00, 2, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 21'h1FFFF0, 8'h00, 1, 8'h00};

        RESET        = 1'b1;
        bus.a_req    = 1'b0;
        bus.a_rd_n   = 1'b0;
        bus.a_addr   = '0;
        bus.a_din    = '0;
        bus.b_req    = 1'b0;
        bus.b_addr   = '0;
        bus.mem_dout = '0;
        bus.mem_ack  = 1'b0;

        // Reset values
        repeat (3) next_cycle();
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_cmd", 32'({bus.mem_we, bus.mem_addr, bus.mem_din}), 32'd0);
        check("rst_dout", 32'({bus.a_dout, bus.b_dout}), 32'd0);
        check("rst_b_valid", 32'(bus.b_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        bus.a_req = 1'b1;
        #1;
        check("rst_a_wait_follows_req_hi", 32'(bus.a_wait), 32'd1);
        bus.a_req = 1'b0;
        #1;
        check("rst_a_wait_follows_req_lo", 32'(bus.a_wait), 32'd0);
        next_cycle();
        RESET = 1'b0;
        next_cycle();

        // Single transactions from the table
        for (int i = 0; i < 8; i++) begin
            ack_delay = vecs[i].n;
            exp_q.push_back(pack(!vecs[i].is_b && vecs[i].rd_n, vecs[i].addr, vecs[i].din));
            next_cycle();
            t0 = cyc;
            if (vecs[i].is_b) begin
                bus.b_req  = 1'b1;
                bus.b_addr = vecs[i].addr;
                wait_b_valid(40, at);
                check($sformatf("vec%0d_b_valid_cycle", i), 32'(at - t0), 32'(3 + vecs[i].n));
                check($sformatf("vec%0d_b_dout", i), 32'(bus.b_dout), 32'(vecs[i].exp_data));
            end else begin
                bus.a_req  = 1'b1;
                bus.a_rd_n = vecs[i].rd_n;
                bus.a_addr = vecs[i].addr;
                bus.a_din  = vecs[i].din;
                #1;
                check($sformatf("vec%0d_a_wait_same_cycle", i), 32'(bus.a_wait), 32'd1);
                wait_a_free(40, at);
                check($sformatf("vec%0d_a_free_cycle", i), 32'(at - t0), 32'(3 + vecs[i].n));
                check($sformatf("vec%0d_a_dout", i), 32'(bus.a_dout), 32'(vecs[i].exp_data));
            end
            check($sformatf("vec%0d_mem_req_cycle", i), 32'(last_req_cyc - t0), 32'd2);
            next_cycle();
        end
        check("table_err_clear", 32'(bus.err), 32'd0);

        same_cycle_ab();

        // Starvation guard: B re-requests on every completion while A waits.
        ack_delay   = 1;
        refill_left = 4;
        bv0         = bv_cnt;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(pack(1'b0, 21'h100000 + 21'(k), 8'h00));
        end
        exp_q.push_back(pack(1'b0, 21'h000300, 8'h00));
        exp_q.push_back(pack(1'b0, 21'h100004, 8'h00));
        next_cycle();
        t0 = cyc;
        bus.a_req  = 1'b1;
        bus.a_rd_n = 1'b0;
        bus.a_addr = 21'h000300;
        bus.b_req  = 1'b1;
        bus.b_addr = 21'h100000;
        wait_a_free(60, at);
        check("streak_a_free_cycle", 32'(at - t0), 32'd16);
        check("streak_a_dout", 32'(bus.a_dout), 32'hA5);
        wait_b_valid(20, at);
        check("streak_last_b_cycle", 32'(at - t0), 32'd19);
        check("streak_last_b_dout", 32'(bus.b_dout), 32'hA1);
        check("streak_b_count", 32'(bv_cnt - bv0), 32'd5);
        check("streak_queue_drained", 32'(exp_q.size()), 32'd0);
        next_cycle();

        // After A has been served the streak restarts and B wins again.
        same_cycle_ab();

        // Duplicate b_req while B is pending is dropped.
        ack_delay = 3;
        bv0       = bv_cnt;
        exp_q.push_back(pack(1'b0, 21'h000077, 8'h00));
        next_cycle();
        t0 = cyc;
        bus.b_req  = 1'b1;
        bus.b_addr = 21'h000077;
        next_cycle();
        bus.b_req  = 1'b1;
        bus.b_addr = 21'h000088;
        wait_b_valid(20, at);
        check("dup_b_valid_cycle", 32'(at - t0), 32'd6);
        check("dup_b_dout", 32'(bus.b_dout), 32'hD2);
        repeat (10) next_cycle();
        check("dup_b_count", 32'(bv_cnt - bv0), 32'd1);
        check("dup_queue_drained", 32'(exp_q.size()), 32'd0);

        // Watchdog: memory never acks an A read.
        mem_on = 1'b0;
        exp_q.push_back(pack(1'b0, 21'h000400, 8'h00));
        next_cycle();
        t0 = cyc;
        bus.a_req  = 1'b1;
        bus.a_rd_n = 1'b0;
        bus.a_addr = 21'h000400;
        wait_a_free(300, at);
        check("wd_mem_req_cycle", 32'(last_req_cyc - t0), 32'd2);
        check("wd_a_free_cycle", 32'(at - t0), 32'd258);
        check("wd_a_dout", 32'(bus.a_dout), 32'hFF);
        check("wd_err_set", 32'(bus.err), 32'd1);
        next_cycle();
        mem_on    = 1'b1;
        ack_delay = 1;
        exp_q.push_back(pack(1'b0, 21'h000455, 8'h00));
        next_cycle();
        t0 = cyc;
        bus.b_req  = 1'b1;
        bus.b_addr = 21'h000455;
        wait_b_valid(20, at);
        check("wd_next_b_cycle", 32'(at - t0), 32'd4);
        check("wd_next_b_dout", 32'(bus.b_dout), 32'hF0);
        check("wd_err_sticky", 32'(bus.err), 32'd1);
        next_cycle();

        // RESET while B is outstanding and A is pending.
        mem_on = 1'b0;
        bv0    = bv_cnt;
        exp_q.push_back(pack(1'b0, 21'h000600, 8'h00));
        next_cycle();
        t0 = cyc;
        bus.a_req  = 1'b1;
        bus.a_rd_n = 1'b0;
        bus.a_addr = 21'h000500;
        bus.b_req  = 1'b1;
        bus.b_addr = 21'h000600;
        repeat (4) next_cycle();
        check("rw_state_wait_b", 32'(state_dbg), 32'd3);
        check("rw_a_wait_before", 32'(bus.a_wait), 32'd1);
        next_cycle();
        RESET = 1'b1;
        force_ack = 1'b1;
        next_cycle();
        RESET = 1'b0;
        check("rw_state_idle", 32'(state_dbg), 32'd0);
        check("rw_mem_req_low", 32'(bus.mem_req), 32'd0);
        check("rw_a_wait_low", 32'(bus.a_wait), 32'd0);
        check("rw_err_cleared", 32'(bus.err), 32'd0);
        next_cycle();
        check("rw_stale_ack_no_b_valid", 32'(bus.b_valid), 32'd0);
        check("rw_b_dout_reset", 32'(bus.b_dout), 32'd0);
        repeat (8) next_cycle();
        check("rw_no_b_valid_after", 32'(bv_cnt - bv0), 32'd0);
        check("rw_state_stays_idle", 32'(state_dbg), 32'd0);
        check("rw_queue_drained", 32'(exp_q.size()), 32'd0);
        mem_on = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
